// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter. The data, weight and op store
// instances all use these types.
package bram_arb_pkg;

  // Arbiter ownership states. IDLE and DRAIN never drive the BRAM.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENGINE = 2'd1,
    DRAIN  = 2'd2,
    HOST   = 2'd3
  } state_t;

  // Which requester issued a read that is still in flight.
  typedef enum logic {
    OWN_ENG  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  // One read tag travels alongside each BRAM read until its data comes back.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  // A BRAM access is a read when it is enabled and is not a write.
  function automatic logic is_read(input logic en, input logic we);
    return en & ~we;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Bundles the host, engine and BRAM-side signals of one arbiter instance.
//
// Handshake semantics:
//  - Host: host_busy_in frames a whole transaction. Strobes (host_we_in /
//    host_re_in) are legal only while host_grant_out is high. A host read is
//    answered by exactly one host_rvalid_out pulse, READ_LATENCY cycles later.
//  - Engine: eng_req_in is a request held until it is accepted. An access
//    transfers in any cycle where eng_req_in and eng_grant_out are both high.
//    A read is answered by exactly one eng_rvalid_out pulse, READ_LATENCY
//    cycles after its grant cycle.
//  - rdata is zero whenever the matching rvalid is low.
interface bram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  logic                  host_busy_in;
  logic [ADDR_WIDTH-1:0] host_addr_in;
  logic [DATA_WIDTH-1:0] host_data_in;
  logic                  host_we_in;
  logic                  host_re_in;
  logic                  host_grant_out;
  logic [DATA_WIDTH-1:0] host_rdata_out;
  logic                  host_rvalid_out;

  logic                  eng_req_in;
  logic [ADDR_WIDTH-1:0] eng_addr_in;
  logic [DATA_WIDTH-1:0] eng_data_in;
  logic                  eng_we_in;
  logic                  eng_grant_out;
  logic [DATA_WIDTH-1:0] eng_rdata_out;
  logic                  eng_rvalid_out;

  logic [ADDR_WIDTH-1:0] bram_addr_out;
  logic [DATA_WIDTH-1:0] bram_data_out;
  logic                  bram_we_out;
  logic                  bram_en_out;
  logic [DATA_WIDTH-1:0] bram_data_in;

  // Arbiter side.
  modport slave (
    input  host_busy_in, host_addr_in, host_data_in, host_we_in, host_re_in,
    output host_grant_out, host_rdata_out, host_rvalid_out,
    input  eng_req_in, eng_addr_in, eng_data_in, eng_we_in,
    output eng_grant_out, eng_rdata_out, eng_rvalid_out,
    output bram_addr_out, bram_data_out, bram_we_out, bram_en_out,
    input  bram_data_in
  );

  // Requesters and BRAM side.
  modport master (
    output host_busy_in, host_addr_in, host_data_in, host_we_in, host_re_in,
    input  host_grant_out, host_rdata_out, host_rvalid_out,
    output eng_req_in, eng_addr_in, eng_data_in, eng_we_in,
    input  eng_grant_out, eng_rdata_out, eng_rvalid_out,
    input  bram_addr_out, bram_data_out, bram_we_out, bram_en_out,
    output bram_data_in
  );
endinterface

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// Delay line of read tags, DEPTH stages deep, matching the BRAM read latency
// so each tag reaches the tail in the same cycle as its read data.
module rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  rd_tag_t i_push,
  output rd_tag_t o_tail
);

  rd_tag_t r_stage [DEPTH];

  // Shift one tag per cycle; reset discards every read in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_push;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tail = r_stage[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between the UART host controller and the
// inference engine. The host owns the port for a whole busy-framed
// transaction; the engine owns it otherwise. Every owner change passes
// through DRAIN so reads in flight return to the requester that issued them.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  bram_port_arbiter_if.slave  bus,
  output state_t              dbg_state_out
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_next_cnt;

  logic                  w_host_grant;
  logic                  w_eng_grant;
  logic                  w_en;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  rd_tag_t               w_push;
  rd_tag_t               w_tail;
  logic                  w_host_rvalid;
  logic                  w_eng_rvalid;

  // State register and drain counter; the state is the only grant source.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state logic. DRAIN holds for exactly READ_LATENCY cycles: the counter
  // is loaded on entry and the exit is taken on the cycle it decrements to 0.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.host_busy_in)    w_next_state = HOST;
        else if (bus.eng_req_in) w_next_state = ENGINE;
      end
      ENGINE: begin
        if (bus.host_busy_in) begin
          w_next_state = DRAIN;
          w_next_cnt   = DRAIN_LOAD;
        end else if (!bus.eng_req_in) begin
          w_next_state = IDLE;
        end
      end
      HOST: begin
        if (!bus.host_busy_in) begin
          w_next_state = DRAIN;
          w_next_cnt   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (r_cnt <= CNT_ONE) begin
          w_next_cnt   = '0;
          w_next_state = bus.host_busy_in ? HOST : IDLE;
        end else begin
          w_next_cnt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // BRAM mux and grants, combinational from the state (no added latency).
  always_comb begin
    w_host_grant = 1'b0;
    w_eng_grant  = 1'b0;
    w_en         = 1'b0;
    w_we         = 1'b0;
    w_addr       = '0;
    w_data       = '0;
    case (r_state)
      ENGINE: begin
        w_eng_grant = bus.eng_req_in;
        w_en        = bus.eng_req_in;
        w_we        = bus.eng_req_in & bus.eng_we_in;
        w_addr      = bus.eng_addr_in;
        w_data      = bus.eng_data_in;
      end
      HOST: begin
        // With both strobes set the write wins, so no read is tagged.
        w_host_grant = 1'b1;
        w_en         = bus.host_we_in | bus.host_re_in;
        w_we         = bus.host_we_in;
        w_addr       = bus.host_addr_in;
        w_data       = bus.host_data_in;
      end
      default: ;
    endcase
  end

  assign w_push.valid = is_read(w_en, w_we);
  assign w_push.owner = (r_state == HOST) ? OWN_HOST : OWN_ENG;

  rd_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rd_tag_pipe (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_push (w_push),
    .o_tail (w_tail)
  );

  assign w_host_rvalid = w_tail.valid && (w_tail.owner == OWN_HOST);
  assign w_eng_rvalid  = w_tail.valid && (w_tail.owner == OWN_ENG);

  assign bus.host_grant_out  = w_host_grant;
  assign bus.eng_grant_out   = w_eng_grant;
  assign bus.host_rvalid_out = w_host_rvalid;
  assign bus.eng_rvalid_out  = w_eng_rvalid;
  assign bus.host_rdata_out  = w_host_rvalid ? bus.bram_data_in : '0;
  assign bus.eng_rdata_out   = w_eng_rvalid  ? bus.bram_data_in : '0;
  assign bus.bram_en_out     = w_en;
  assign bus.bram_we_out     = w_we;
  assign bus.bram_addr_out   = w_addr;
  assign bus.bram_data_out   = w_data;
  assign dbg_state_out       = r_state;

  // Host strobes are only legal while the host holds the grant.
  always_ff @(posedge clk_in) begin
    if (!rst_in && r_state != HOST) begin
      assert (!(bus.host_we_in || bus.host_re_in));
    end
  end

endmodule
